// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - default register-file dimensions and address-width helper
package rf_pkg;

  localparam int unsigned RF_XLEN  = 32;
  localparam int unsigned RF_NREGS = 32;
  localparam int unsigned RF_NRD   = 2;
  localparam int unsigned RF_NWR   = 2;

  function automatic int unsigned rf_addr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-write (busy) bits with reserve-over-write priority
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREGS = RF_NREGS,
  parameter int unsigned NWR   = RF_NWR,
  parameter int unsigned AW    = rf_addr_w(RF_NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] waddr,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  output logic [NREGS-1:0]  busy,
  output logic              any_busy
);

  logic [NREGS-1:0] r_busy;

  // Reserve is applied after the write clears so a new producer keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (waddr[j*AW +: AW] != '0)) begin
          r_busy[waddr[j*AW +: AW]] <= 1'b0;
        end
      end
      if (rsv_en && (rsv_addr != '0)) begin
        r_busy[rsv_addr] <= 1'b1;
      end
    end
  end

  assign busy     = r_busy;
  assign any_busy = |r_busy[NREGS-1:1];

endmodule

// File: rtl/multiport_regfile.sv
// rtl/multiport_regfile.sv - multiport register file with busy scoreboard; RF_BYPASS_EN enables same-cycle forwarding
module multiport_regfile
  import rf_pkg::*;
#(
  parameter int unsigned XLEN  = RF_XLEN,
  parameter int unsigned NREGS = RF_NREGS,
  parameter int unsigned NRD   = RF_NRD,
  parameter int unsigned NWR   = RF_NWR,
  localparam int unsigned AW   = rf_addr_w(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                any_busy
);

  logic [XLEN-1:0]  r_rf [NREGS];
  logic [NREGS-1:0] w_busy;

  // Ascending port order makes the highest-index writer win on address collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) begin
        r_rf[k] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (waddr[j*AW +: AW] != '0)) begin
          r_rf[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
        end
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (w_busy),
    .any_busy (any_busy)
  );

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_rb;

    assign w_addr = raddr[gi*AW +: AW];

    always_comb begin
      w_data = r_rf[w_addr];
      w_rb   = w_busy[w_addr];
`ifdef RF_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (waddr[j*AW +: AW] == w_addr)) begin
          w_data = wdata[j*XLEN +: XLEN];
          w_rb   = rsv_en && (rsv_addr == w_addr);
        end
      end
`endif
      // Reset gating keeps forwarded inputs from leaking out while rst_n is low.
      if (!rst_n || (w_addr == '0)) begin
        w_data = '0;
        w_rb   = 1'b0;
      end
    end

    assign rdata[gi*XLEN +: XLEN] = w_data;
    assign rbusy[gi]              = w_rb;
  end

endmodule

// File: tb/tb_multiport_regfile.sv
// tb/tb_multiport_regfile.sv - scoreboard-driven self-checking bench for multiport_regfile
module tb_multiport_regfile;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW = 5;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                any_busy;

  int total;
  int bad;
  exp_t q[$];
  logic [XLEN-1:0] mdl [NREGS];

  multiport_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .any_busy (any_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we       = '0;
    waddr    = '0;
    wdata    = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  task automatic drv_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we[p]              = 1'b1;
    waddr[p*AW +: AW]  = a;
    wdata[p*XLEN +: XLEN] = d;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    raddr = '0;
    idle();
    drv_wr(0, 5'd5, 32'hAAAA5555);
    drv_wr(1, 5'd5, 32'h5555AAAA);
    rsv_en = 1'b1; rsv_addr = 5'd5;
    raddr[0 +: AW] = 5'd5;
    repeat (3) tick();
    total++;
    if (rdata[31:0] !== 32'h0) begin bad++; $display("FAIL reset_hold_data got=%h exp=%h", rdata[31:0], 32'h0); end
    idle();
    rst_n = 1'b1;
    tick();
    q.push_back('{addr: 5'd5, data: 32'h0, busy: 1'b0});
    e = q.pop_front();
    raddr[0 +: AW] = e.addr;
    #1;
    total++;
    if (rdata[31:0] !== e.data) begin bad++; $display("FAIL reset_x5_data got=%h exp=%h", rdata[31:0], e.data); end
    total++;
    if (rbusy[0] !== e.busy) begin bad++; $display("FAIL reset_x5_busy got=%b exp=%b", rbusy[0], e.busy); end
    total++;
    if (any_busy !== 1'b0) begin bad++; $display("FAIL reset_any_busy got=%b exp=0", any_busy); end
  endtask

  task automatic test_x0_guard();
    exp_t e;
    idle();
    drv_wr(0, 5'd0, 32'hDEADBEEF);
    rsv_en = 1'b1; rsv_addr = 5'd0;
    raddr[0 +: AW] = 5'd0;
    #1;
    total++;
    if (rdata[31:0] !== 32'h0) begin bad++; $display("FAIL x0_same_cycle got=%h exp=%h", rdata[31:0], 32'h0); end
    tick();
    idle();
    q.push_back('{addr: 5'd0, data: 32'h0, busy: 1'b0});
    e = q.pop_front();
    raddr[0 +: AW] = e.addr;
    #1;
    total++;
    if (rdata[31:0] !== e.data) begin bad++; $display("FAIL x0_data got=%h exp=%h", rdata[31:0], e.data); end
    total++;
    if (rbusy[0] !== e.busy) begin bad++; $display("FAIL x0_busy got=%b exp=%b", rbusy[0], e.busy); end
    total++;
    if (any_busy !== 1'b0) begin bad++; $display("FAIL x0_any_busy got=%b exp=0", any_busy); end
  endtask

  task automatic test_write_conflict();
    exp_t e;
    idle();
    drv_wr(0, 5'd7, 32'h11111111);
    drv_wr(1, 5'd7, 32'h22222222);
    tick();
    idle();
    q.push_back('{addr: 5'd7, data: 32'h22222222, busy: 1'b0});
    e = q.pop_front();
    raddr[AW +: AW] = e.addr;
    #1;
    total++;
    if (rdata[63:32] !== e.data) begin bad++; $display("FAIL conflict_x7 got=%h exp=%h", rdata[63:32], e.data); end
    total++;
    if (rbusy[1] !== e.busy) begin bad++; $display("FAIL conflict_x7_busy got=%b exp=%b", rbusy[1], e.busy); end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd3;
    tick();
    idle();
    q.push_back('{addr: 5'd3, data: 32'h0, busy: 1'b1});
    e = q.pop_front();
    raddr[0 +: AW] = e.addr;
    #1;
    total++;
    if (rbusy[0] !== e.busy) begin bad++; $display("FAIL sb_reserve_busy got=%b exp=%b", rbusy[0], e.busy); end
    total++;
    if (any_busy !== 1'b1) begin bad++; $display("FAIL sb_reserve_any got=%b exp=1", any_busy); end
    drv_wr(0, 5'd3, 32'h5);
    tick();
    idle();
    q.push_back('{addr: 5'd3, data: 32'h5, busy: 1'b0});
    e = q.pop_front();
    #1;
    total++;
    if (rbusy[0] !== e.busy) begin bad++; $display("FAIL sb_write_busy got=%b exp=%b", rbusy[0], e.busy); end
    total++;
    if (rdata[31:0] !== e.data) begin bad++; $display("FAIL sb_write_data got=%h exp=%h", rdata[31:0], e.data); end
    total++;
    if (any_busy !== 1'b0) begin bad++; $display("FAIL sb_write_any got=%b exp=0", any_busy); end
    drv_wr(1, 5'd3, 32'h5);
    rsv_en = 1'b1; rsv_addr = 5'd3;
    tick();
    idle();
    q.push_back('{addr: 5'd3, data: 32'h5, busy: 1'b1});
    e = q.pop_front();
    #1;
    total++;
    if (rbusy[0] !== e.busy) begin bad++; $display("FAIL sb_rsv_wr_busy got=%b exp=%b", rbusy[0], e.busy); end
    total++;
    if (rdata[31:0] !== e.data) begin bad++; $display("FAIL sb_rsv_wr_data got=%h exp=%h", rdata[31:0], e.data); end
    total++;
    if (any_busy !== 1'b1) begin bad++; $display("FAIL sb_rsv_wr_any got=%b exp=1", any_busy); end
    drv_wr(0, 5'd3, 32'h5);
    tick();
    idle();
  endtask

  task automatic test_bypass();
    exp_t e;
    logic [XLEN-1:0] same_exp;
    logic            same_busy;
    idle();
    drv_wr(0, 5'd9, 32'h0BADBEEF);
    tick();
    idle();
    drv_wr(1, 5'd9, 32'hCAFEF00D);
    raddr[0 +: AW] = 5'd9;
`ifdef RF_BYPASS_EN
    same_exp = 32'hCAFEF00D;
`else
    same_exp = 32'h0BADBEEF;
`endif
    #1;
    total++;
    if (rdata[31:0] !== same_exp) begin bad++; $display("FAIL bypass_same_cycle got=%h exp=%h", rdata[31:0], same_exp); end
    tick();
    idle();
    q.push_back('{addr: 5'd9, data: 32'hCAFEF00D, busy: 1'b0});
    e = q.pop_front();
    #1;
    total++;
    if (rdata[31:0] !== e.data) begin bad++; $display("FAIL bypass_after_edge got=%h exp=%h", rdata[31:0], e.data); end
    drv_wr(0, 5'd9, 32'h13572468);
    rsv_en = 1'b1; rsv_addr = 5'd9;
`ifdef RF_BYPASS_EN
    same_busy = 1'b1;
`else
    same_busy = 1'b0;
`endif
    #1;
    total++;
    if (rbusy[0] !== same_busy) begin bad++; $display("FAIL bypass_rsv_busy got=%b exp=%b", rbusy[0], same_busy); end
    tick();
    idle();
    total++;
    if (rbusy[0] !== 1'b1) begin bad++; $display("FAIL bypass_rsv_after got=%b exp=1", rbusy[0]); end
    drv_wr(0, 5'd9, 32'hCAFEF00D);
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    exp_t e0;
    exp_t e1;
    logic [AW-1:0]   a0, a1;
    logic [XLEN-1:0] d0, d1;
    idle();
    for (int k = 0; k < NREGS / 2; k++) begin
      d0 = $urandom;
      d1 = $urandom;
      drv_wr(0, AW'(2 * k), d0);
      drv_wr(1, AW'(2 * k + 1), d1);
      mdl[2 * k]     = (k == 0) ? '0 : d0;
      mdl[2 * k + 1] = d1;
      tick();
    end
    for (int n = 0; n < 24; n++) begin
      idle();
      a0 = AW'($urandom_range(0, NREGS - 1));
      a1 = (n % 4 == 0) ? a0 : AW'($urandom_range(0, NREGS - 1));
      d0 = $urandom;
      d1 = $urandom;
      drv_wr(0, a0, d0);
      drv_wr(1, a1, d1);
      tick();
      if (a0 != 0) mdl[a0] = d0;
      if (a1 != 0) mdl[a1] = d1;
      q.push_back('{addr: a0, data: mdl[a0], busy: 1'b0});
      q.push_back('{addr: a1, data: mdl[a1], busy: 1'b0});
      idle();
      e0 = q.pop_front();
      e1 = q.pop_front();
      raddr[0 +: AW]  = e0.addr;
      raddr[AW +: AW] = e1.addr;
      #1;
      total++;
      if (rdata[31:0] !== e0.data) begin bad++; $display("FAIL b2b_p0 n=%0d addr=%0d got=%h exp=%h", n, e0.addr, rdata[31:0], e0.data); end
      total++;
      if (rdata[63:32] !== e1.data) begin bad++; $display("FAIL b2b_p1 n=%0d addr=%0d got=%h exp=%h", n, e1.addr, rdata[63:32], e1.data); end
      total++;
      if (rbusy !== {e1.busy, e0.busy}) begin bad++; $display("FAIL b2b_busy n=%0d got=%b exp=%b", n, rbusy, {e1.busy, e0.busy}); end
    end
    idle();
  endtask

  task automatic test_async_reset();
    exp_t e;
    idle();
    drv_wr(0, 5'd4, 32'h1234);
    rsv_en = 1'b1; rsv_addr = 5'd6;
    tick();
    idle();
    raddr[0 +: AW]  = 5'd4;
    raddr[AW +: AW] = 5'd6;
    #1;
    total++;
    if (rdata[31:0] !== 32'h1234) begin bad++; $display("FAIL arst_pre_x4 got=%h exp=%h", rdata[31:0], 32'h1234); end
    total++;
    if (any_busy !== 1'b1) begin bad++; $display("FAIL arst_pre_any got=%b exp=1", any_busy); end
    drv_wr(1, 5'd4, 32'h9999);
    #1;
    rst_n = 1'b0;
    q.push_back('{addr: 5'd4, data: 32'h0, busy: 1'b0});
    e = q.pop_front();
    #1;
    total++;
    if (rdata[31:0] !== e.data) begin bad++; $display("FAIL arst_x4 got=%h exp=%h", rdata[31:0], e.data); end
    total++;
    if (rbusy[1] !== 1'b0) begin bad++; $display("FAIL arst_x6_busy got=%b exp=0", rbusy[1]); end
    total++;
    if (any_busy !== 1'b0) begin bad++; $display("FAIL arst_any got=%b exp=0", any_busy); end
    tick();
    idle();
    rst_n = 1'b1;
    tick();
    total++;
    if (rdata[31:0] !== 32'h0) begin bad++; $display("FAIL arst_post_x4 got=%h exp=%h", rdata[31:0], 32'h0); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_x0_guard();
    test_write_conflict();
    test_scoreboard();
    test_bypass();
    test_back_to_back();
    test_async_reset();
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
